// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition codes, flag indices and IT state encoding
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IT_RUN = 1'b1
  } it_state_t;

  // A single bank still needs a one-bit select so the port never collapses to zero width.
  function automatic int bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/cond_flag_unit_if.sv
// rtl/cond_flag_unit_if.sv - flag, bank and IT control bundle for cond_flag_unit
interface cond_flag_unit_if #(
  parameter int BANKS  = 2,
  parameter int MAX_IT = 4
);
  import cond_pkg::*;

  localparam int BW = bank_width(BANKS);
  localparam int CW = $clog2(MAX_IT + 1);

  logic [3:0]        flags_in;
  logic              flag_ld;
  logic [3:0]        flag_mask;
  logic              save;
  logic              restore;
  logic [BW-1:0]     bank_sel;
  logic [3:0]        cond_code;
  logic              instr_adv;
  logic              it_start;
  logic [3:0]        it_cond;
  logic [CW-1:0]     it_len;
  logic [MAX_IT-1:0] it_te;

  logic              c;
  logic              z;
  logic              n;
  logic              v;
  logic              cond_pass;
  logic              it_active;
  logic [CW-1:0]     it_remaining;
  logic              it_err;

  modport master (
    output flags_in, flag_ld, flag_mask, save, restore, bank_sel,
           cond_code, instr_adv, it_start, it_cond, it_len, it_te,
    input  c, z, n, v, cond_pass, it_active, it_remaining, it_err
  );

  modport slave (
    input  flags_in, flag_ld, flag_mask, save, restore, bank_sel,
           cond_code, instr_adv, it_start, it_cond, it_len, it_te,
    output c, z, n, v, cond_pass, it_active, it_remaining, it_err
  );

endinterface

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator over {C,Z,N,V}
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] code,
  output logic       pass
);

  logic c, z, n, v;

  always_comb begin
    c    = flags[FLAG_C];
    z    = flags[FLAG_Z];
    n    = flags[FLAG_N];
    v    = flags[FLAG_V];
    pass = 1'b0;
    case (code)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - live C/Z/N/V flags, saved banks and IT-block predication
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int BANKS  = 2,
  parameter int MAX_IT = 4
) (
  input  logic            clk,
  input  logic            reset,
  cond_flag_unit_if.slave bus
);

  localparam int BW = bank_width(BANKS);
  localparam int CW = $clog2(MAX_IT + 1);
  localparam int NSLOT = 2 ** BW;

  it_state_t         state_q, state_d;
  logic [3:0]        live_q, live_d;
  logic [3:0]        bank_q [NSLOT];
  logic [3:0]        it_cond_q, it_cond_d;
  logic [MAX_IT-1:0] te_q, te_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic              it_err_q;
  logic              illegal;
  logic              len_bad;
  logic [NSLOT-1:0]  bank_valid;
  logic              bank_ok;
  logic [3:0]        eff_code;
  logic              pass;

  // Select values beyond BANKS map to no bank, so save/restore there is a no-op.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      bank_valid[i] = (i < BANKS);
    end
    bank_ok = bank_valid[bus.bank_sel];
  end

  always_comb begin
    live_d = live_q;
    if (bus.flag_ld) begin
      live_d = (bus.flags_in & bus.flag_mask) | (live_q & ~bus.flag_mask);
    end
    if (bus.restore && bank_ok) begin
      live_d = bank_q[bus.bank_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= 4'b0000;
      it_err_q <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        bank_q[i] <= 4'b0000;
      end
    end else begin
      live_q   <= live_d;
      it_err_q <= illegal;
      // Saves the pre-update flags, which makes a same-bank save+restore a swap.
      if (bus.save && bank_ok) begin
        bank_q[bus.bank_sel] <= live_q;
      end
    end
  end

  always_comb begin
    len_bad = (bus.it_len == '0) || (32'(bus.it_len) > 32'(MAX_IT));
    illegal = bus.it_start &&
              ((state_q == ST_IT_RUN) || len_bad || (bus.it_cond == COND_NV));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      it_cond_q <= 4'b0000;
      te_q      <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      it_cond_q <= it_cond_d;
      te_q      <= te_d;
      rem_q     <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    it_cond_d = it_cond_q;
    te_d      = te_q;
    rem_d     = rem_q;
    eff_code  = bus.cond_code;
    case (state_q)
      ST_IDLE: begin
        // The IT instruction itself retires unpredicated and does not consume a slot.
        if (bus.it_start && !illegal) begin
          state_d   = ST_IT_RUN;
          it_cond_d = bus.it_cond;
          te_d      = bus.it_te;
          rem_d     = bus.it_len;
        end
      end
      ST_IT_RUN: begin
        if (it_cond_q == COND_AL) begin
          eff_code = COND_AL;
        end else begin
          eff_code = {it_cond_q[3:1], it_cond_q[0] ^ ~te_q[0]};
        end
        if (bus.instr_adv && !bus.it_start) begin
          te_d  = te_q >> 1;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  cond_eval u_eval (
    .flags (live_q),
    .code  (eff_code),
    .pass  (pass)
  );

  assign bus.c            = live_q[FLAG_C];
  assign bus.z            = live_q[FLAG_Z];
  assign bus.n            = live_q[FLAG_N];
  assign bus.v            = live_q[FLAG_V];
  assign bus.cond_pass    = pass;
  assign bus.it_active    = (state_q == ST_IT_RUN);
  assign bus.it_remaining = rem_q;
  assign bus.it_err       = it_err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - scoreboard bench for cond_flag_unit against a slot-queue model
module tb_cond_flag_unit;
  import cond_pkg::*;

  localparam int BANKS  = 3;
  localparam int MAX_IT = 4;
  localparam int CW     = $clog2(MAX_IT + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_flag_unit_if #(.BANKS(BANKS), .MAX_IT(MAX_IT)) bus ();

  cond_flag_unit #(.BANKS(BANKS), .MAX_IT(MAX_IT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]    flags;
    logic          pass;
    logic          active;
    logic [CW-1:0] rem;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_live;
  logic [3:0] m_bank [BANKS];
  logic [3:0] m_slots[$];
  bit         m_err;

  // Conditions come in complementary pairs; the odd member inverts the even one.
  function automatic bit ref_pass(input logic [3:0] f, input logic [3:0] code);
    bit c, z, n, v, b;
    c = f[3]; z = f[2]; n = f[1]; v = f[0];
    case (code[3:1])
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return b ^ code[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update();
    logic [3:0] nl;
    bit         ill;
    int         sel;
    int         len;
    if (reset) begin
      m_live = 4'b0000;
      foreach (m_bank[i]) m_bank[i] = 4'b0000;
      m_slots.delete();
      m_err = 1'b0;
      return;
    end
    sel = int'(bus.bank_sel);
    nl  = m_live;
    if (bus.flag_ld)
      for (int b = 0; b < 4; b++) if (bus.flag_mask[b]) nl[b] = bus.flags_in[b];
    if (bus.restore && sel < BANKS) nl = m_bank[sel];
    if (bus.save && sel < BANKS) m_bank[sel] = m_live;
    m_live = nl;
    len = int'(bus.it_len);
    ill = bus.it_start && (m_slots.size() != 0 || len < 1 || len > MAX_IT || bus.it_cond == 4'hF);
    m_err = ill;
    if (bus.it_start) begin
      if (!ill)
        for (int i = 0; i < len; i++)
          m_slots.push_back(bus.it_cond == 4'hE ? 4'hE
                            : {bus.it_cond[3:1], bus.it_cond[0] ^ ~bus.it_te[i]});
    end else if (bus.instr_adv && m_slots.size() != 0) begin
      void'(m_slots.pop_front());
    end
  endtask

  task automatic cyc();
    exp_t e;
    e.flags  = m_live;
    e.pass   = ref_pass(m_live, (m_slots.size() != 0) ? m_slots[0] : bus.cond_code);
    e.active = (m_slots.size() != 0);
    e.rem    = CW'(m_slots.size());
    e.err    = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    reset         = 1'b0;
    bus.flags_in  = 4'b0000;
    bus.flag_ld   = 1'b0;
    bus.flag_mask = 4'b0000;
    bus.save      = 1'b0;
    bus.restore   = 1'b0;
    bus.bank_sel  = '0;
    bus.cond_code = COND_AL;
    bus.instr_adv = 1'b0;
    bus.it_start  = 1'b0;
    bus.it_cond   = COND_AL;
    bus.it_len    = '0;
    bus.it_te     = '0;
  endtask

  task automatic load(input logic [3:0] val);
    idle();
    bus.flags_in  = val;
    bus.flag_mask = 4'b1111;
    bus.flag_ld   = 1'b1;
    cyc();
  endtask

  task automatic start_it(input logic [3:0] cond, input int len, input logic [MAX_IT-1:0] te);
    idle();
    bus.it_start = 1'b1;
    bus.it_cond  = cond;
    bus.it_len   = CW'(len);
    bus.it_te    = te;
    cyc();
  endtask

  task automatic adv(input int count);
    for (int i = 0; i < count; i++) begin
      idle();
      bus.instr_adv = 1'b1;
      cyc();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("flags", 32'({bus.c, bus.z, bus.n, bus.v}), 32'(e.flags));
        chk("cond_pass", 32'(bus.cond_pass), 32'(e.pass));
        chk("it_active", 32'(bus.it_active), 32'(e.active));
        chk("it_remaining", 32'(bus.it_remaining), 32'(e.rem));
        chk("it_err", 32'(bus.it_err), 32'(e.err));
      end
    end
  end

  initial begin : stimulus
    idle();
    reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    cyc();
    idle();
    cyc();

    // Masked load then LS/HI on the result
    idle();
    bus.flags_in = 4'b1111; bus.flag_mask = 4'b0101; bus.flag_ld = 1'b1;
    cyc();
    idle(); bus.cond_code = COND_LS; cyc();
    idle(); bus.cond_code = COND_HI; cyc();

    // Same-bank save+restore swap, then again against a competing load
    load(4'b0110);
    idle(); bus.save = 1'b1; bus.bank_sel = 2'd1; cyc();
    load(4'b1010);
    idle(); bus.save = 1'b1; bus.restore = 1'b1; bus.bank_sel = 2'd1; cyc();
    idle(); bus.restore = 1'b1; bus.bank_sel = 2'd1; cyc();
    idle();
    bus.save = 1'b1; bus.restore = 1'b1; bus.bank_sel = 2'd1;
    bus.flag_ld = 1'b1; bus.flags_in = 4'b1111; bus.flag_mask = 4'b1111;
    cyc();
    idle(); cyc();

    // Out-of-range bank select
    load(4'b0011);
    idle(); bus.save = 1'b1; bus.bank_sel = 2'd3; cyc();
    idle(); bus.restore = 1'b1; bus.bank_sel = 2'd3; cyc();
    idle(); cyc();

    // EQ block with then/else/then on Z=1
    load(4'b0100);
    start_it(COND_EQ, 3, 4'b0101);
    adv(3);
    idle(); cyc();

    // Predicated flag update feeds the following slot
    load(4'b0000);
    start_it(COND_NE, 2, 4'b0011);
    idle(); bus.instr_adv = 1'b1;
    bus.flag_ld = 1'b1; bus.flag_mask = 4'b0100; bus.flags_in = 4'b0100;
    cyc();
    adv(1);
    idle(); cyc();

    // Illegal IT requests
    start_it(COND_EQ, 0, 4'b1111);
    idle(); cyc();
    start_it(COND_GE, 5, 4'b1111);
    idle(); cyc();
    start_it(COND_GT, 3, 4'b0010);
    idle(); bus.it_start = 1'b1; bus.it_cond = COND_EQ; bus.it_len = 3'd2;
    bus.instr_adv = 1'b1; cyc();
    adv(3);
    start_it(COND_NV, 2, 4'b0000);
    idle(); cyc();

    // AL block ignores else bits; full-length block
    start_it(COND_AL, MAX_IT, 4'b0000);
    adv(MAX_IT);
    idle(); cyc();

    // IT start and instr_adv together while idle
    idle(); bus.it_start = 1'b1; bus.it_cond = COND_MI; bus.it_len = 3'd2;
    bus.it_te = 4'b0010; bus.instr_adv = 1'b1; cyc();
    adv(2);

    // Reset in the middle of a block
    load(4'b1111);
    start_it(COND_CS, 3, 4'b0111);
    adv(1);
    idle(); reset = 1'b1; cyc();
    idle(); bus.cond_code = COND_AL; cyc();

    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.flags_in  = 4'($urandom);
      bus.flag_ld   = ($urandom_range(0, 3) == 0);
      bus.flag_mask = 4'($urandom);
      bus.save      = ($urandom_range(0, 5) == 0);
      bus.restore   = ($urandom_range(0, 5) == 0);
      bus.bank_sel  = 2'($urandom_range(0, 3));
      bus.cond_code = 4'($urandom);
      bus.instr_adv = ($urandom_range(0, 1) == 0);
      bus.it_start  = ($urandom_range(0, 7) == 0);
      bus.it_cond   = 4'($urandom);
      bus.it_len    = CW'($urandom_range(0, 5));
      bus.it_te     = 4'($urandom);
      cyc();
    end

    idle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
